// File: rtl/write_merge_buffer.sv
// Merges up to four CPU word writes to the same line into a single RAM line write.
// Optional idle-flush timer is compiled in by defining WMB_TIMEOUT_EN.
module write_merge_buffer #(
    parameter int CPU_W   = 32,
    parameter int LINE_W  = 4 * CPU_W,
    parameter int OFF_W   = 4,
    parameter int TAG_W   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              IN_CLK,
    input  logic              IN_RESET,
    input  logic              IN_WR_VALID,
    output logic              OUT_WR_READY,
    input  logic [CPU_W-1:0]  IN_WR_DATA,
    input  logic [TAG_W-1:0]  IN_WR_LINE_ADDR,
    input  logic [OFF_W-1:0]  IN_WR_ADDR_OFFSET,
    input  logic              IN_FLUSH,
    output logic              OUT_RAM_WR_VALID,
    input  logic              IN_RAM_WR_READY,
    output logic [LINE_W-1:0] OUT_RAM_DATA,
    output logic [TAG_W-1:0]  OUT_RAM_LINE_ADDR,
    output logic [3:0]        OUT_RAM_WORD_MASK,
    output logic              OUT_BUSY
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [LINE_W-1:0]  data_r;
    logic [TAG_W-1:0]   addr_r;
    logic [3:0]         mask_r;
    logic [3:0]         mask_s;
    logic [1:0]         slot_s;
    logic [3:0]         slot_bit_s;
    logic               addr_hit_s;
    logic               ready_s;
    logic               accept_s;
    logic               timeout_s;
    logic               unused_offset_s;

    // Only the word-select bits of the offset matter; byte bits are dropped.
    assign slot_s          = IN_WR_ADDR_OFFSET[OFF_W-1:OFF_W/2];
    assign unused_offset_s = ^IN_WR_ADDR_OFFSET[OFF_W/2-1:0];
    assign slot_bit_s      = 4'b0001 << slot_s;
    assign addr_hit_s      = (IN_WR_LINE_ADDR == addr_r);
    assign accept_s        = IN_WR_VALID & ready_s;

`ifdef WMB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_r;

    assign timeout_s = (cnt_r == CNT_W'(TIMEOUT - 1));

    // Idle-cycle counter; held at zero outside FILL and cleared by every accept.
    always_ff @(posedge IN_CLK or posedge IN_RESET) begin
        if (IN_RESET) begin
            cnt_r <= '0;
        end else if ((state_r != FILL) || accept_s) begin
            cnt_r <= '0;
        end else if (!timeout_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end
`else
    logic [31:0] unused_timeout_s;
    assign unused_timeout_s = 32'(TIMEOUT);
    assign timeout_s        = 1'b0;
`endif

    // Write-side ready: open in IDLE, or in FILL for a same-line write without flush.
    always_comb begin
        ready_s = 1'b0;
        case (state_r)
            IDLE:    ready_s = 1'b1;
            FILL:    ready_s = addr_hit_s & ~IN_FLUSH;
            DRAIN:   ready_s = 1'b0;
            default: ready_s = 1'b0;
        endcase
    end

    // Next-state and next-mask logic.
    always_comb begin
        state_s = state_r;
        mask_s  = mask_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = FILL;
                    mask_s  = slot_bit_s;
                end else begin
                    state_s = IDLE;
                end
            end
            FILL: begin
                if (accept_s) begin
                    mask_s = mask_r | slot_bit_s;
                    if ((mask_r | slot_bit_s) == 4'b1111) begin
                        state_s = DRAIN;
                    end else begin
                        state_s = FILL;
                    end
                end else if (IN_FLUSH || (IN_WR_VALID && !addr_hit_s) || timeout_s) begin
                    state_s = DRAIN;
                end else begin
                    state_s = FILL;
                end
            end
            DRAIN: begin
                if (IN_RAM_WR_READY) begin
                    state_s = IDLE;
                    mask_s  = 4'b0000;
                end else begin
                    state_s = DRAIN;
                end
            end
            default: begin
                state_s = IDLE;
                mask_s  = 4'b0000;
            end
        endcase
    end

    // State, mask, line address and merged data registers.
    always_ff @(posedge IN_CLK or posedge IN_RESET) begin
        if (IN_RESET) begin
            state_r <= IDLE;
            mask_r  <= 4'b0000;
            addr_r  <= '0;
            data_r  <= '0;
        end else begin
            state_r <= state_s;
            mask_r  <= mask_s;
            if (accept_s && (state_r == IDLE)) begin
                addr_r <= IN_WR_LINE_ADDR;
            end
            // Unwritten words keep stale contents; the mask marks them invalid.
            for (int k = 0; k < 4; k++) begin
                if (accept_s && (slot_s == 2'(k))) begin
                    data_r[k*CPU_W +: CPU_W] <= IN_WR_DATA;
                end
            end
        end
    end

    assign OUT_WR_READY      = ready_s;
    assign OUT_RAM_WR_VALID  = (state_r == DRAIN);
    assign OUT_BUSY          = (state_r != IDLE);
    assign OUT_RAM_DATA      = data_r;
    assign OUT_RAM_LINE_ADDR = addr_r;
    assign OUT_RAM_WORD_MASK = mask_r;

endmodule

// File: tb/tb_write_merge_buffer.sv
// Directed self-checking bench for write_merge_buffer; define WMB_TIMEOUT_EN for the timer build.
module tb_write_merge_buffer;

    logic         IN_CLK;
    logic         IN_RESET;
    logic         IN_WR_VALID;
    logic         OUT_WR_READY;
    logic [31:0]  IN_WR_DATA;
    logic [7:0]   IN_WR_LINE_ADDR;
    logic [3:0]   IN_WR_ADDR_OFFSET;
    logic         IN_FLUSH;
    logic         OUT_RAM_WR_VALID;
    logic         IN_RAM_WR_READY;
    logic [127:0] OUT_RAM_DATA;
    logic [7:0]   OUT_RAM_LINE_ADDR;
    logic [3:0]   OUT_RAM_WORD_MASK;
    logic         OUT_BUSY;

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;

    write_merge_buffer #(
        .CPU_W(32), .LINE_W(128), .OFF_W(4), .TAG_W(8), .TIMEOUT(16)
    ) dut (
        .IN_CLK(IN_CLK),
        .IN_RESET(IN_RESET),
        .IN_WR_VALID(IN_WR_VALID),
        .OUT_WR_READY(OUT_WR_READY),
        .IN_WR_DATA(IN_WR_DATA),
        .IN_WR_LINE_ADDR(IN_WR_LINE_ADDR),
        .IN_WR_ADDR_OFFSET(IN_WR_ADDR_OFFSET),
        .IN_FLUSH(IN_FLUSH),
        .OUT_RAM_WR_VALID(OUT_RAM_WR_VALID),
        .IN_RAM_WR_READY(IN_RAM_WR_READY),
        .OUT_RAM_DATA(OUT_RAM_DATA),
        .OUT_RAM_LINE_ADDR(OUT_RAM_LINE_ADDR),
        .OUT_RAM_WORD_MASK(OUT_RAM_WORD_MASK),
        .OUT_BUSY(OUT_BUSY)
    );

    initial IN_CLK = 1'b0;
    always #5 IN_CLK = ~IN_CLK;

    // Count completed RAM handshakes.
    always @(posedge IN_CLK) begin
        if (OUT_RAM_WR_VALID && IN_RAM_WR_READY) hs_cnt++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge IN_CLK);
        #2;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (OUT_WR_READY !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", OUT_WR_READY); end
        checks++; if (OUT_BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", OUT_BUSY); end
        checks++; if (OUT_RAM_WR_VALID !== 1'b0) begin errors++; $display("FAIL reset_ramvalid got %b exp 0", OUT_RAM_WR_VALID); end
        checks++; if (OUT_RAM_WORD_MASK !== 4'b0000) begin errors++; $display("FAIL reset_mask got %b exp 0000", OUT_RAM_WORD_MASK); end
        checks++; if (OUT_RAM_DATA !== 128'h0) begin errors++; $display("FAIL reset_data got %h exp 0", OUT_RAM_DATA); end
        checks++; if (OUT_RAM_LINE_ADDR !== 8'h00) begin errors++; $display("FAIL reset_addr got %h exp 00", OUT_RAM_LINE_ADDR); end
        @(negedge IN_CLK);
        IN_RESET = 1'b0;
        step();
        checks++; if (OUT_BUSY !== 1'b0) begin errors++; $display("FAIL post_reset_busy got %b exp 0", OUT_BUSY); end
    endtask

    task automatic test_full_merge();
        int hs0;
        hs0 = hs_cnt;
        for (int i = 0; i < 4; i++) begin
            IN_WR_VALID = 1'b1;
            IN_WR_LINE_ADDR = 8'h12;
            IN_WR_ADDR_OFFSET = 4'(4 * i);
            IN_WR_DATA = 32'hA0 + 32'(i);
            #1;
            checks++; if (OUT_WR_READY !== 1'b1) begin errors++; $display("FAIL merge_ready%0d got %b exp 1", i, OUT_WR_READY); end
            step();
            IN_WR_VALID = 1'b0;
            #1;
            if (i < 3) begin
                checks++; if ({OUT_BUSY, OUT_RAM_WR_VALID} !== 2'b10) begin errors++; $display("FAIL merge_fill%0d busy/valid got %b exp 10", i, {OUT_BUSY, OUT_RAM_WR_VALID}); end
            end
        end
        checks++; if (OUT_RAM_WR_VALID !== 1'b1) begin errors++; $display("FAIL merge_ramvalid got %b exp 1", OUT_RAM_WR_VALID); end
        checks++; if (OUT_RAM_WORD_MASK !== 4'b1111) begin errors++; $display("FAIL merge_mask got %b exp 1111", OUT_RAM_WORD_MASK); end
        checks++; if (OUT_RAM_DATA !== 128'h000000A3_000000A2_000000A1_000000A0) begin errors++; $display("FAIL merge_data got %h exp 000000a3000000a2000000a1000000a0", OUT_RAM_DATA); end
        checks++; if (OUT_RAM_LINE_ADDR !== 8'h12) begin errors++; $display("FAIL merge_addr got %h exp 12", OUT_RAM_LINE_ADDR); end
        checks++; if (OUT_WR_READY !== 1'b0) begin errors++; $display("FAIL merge_drain_ready got %b exp 0", OUT_WR_READY); end
        step();
        #1;
        checks++; if ({OUT_BUSY, OUT_RAM_WR_VALID, OUT_WR_READY} !== 3'b001) begin errors++; $display("FAIL merge_idle busy/valid/ready got %b exp 001", {OUT_BUSY, OUT_RAM_WR_VALID, OUT_WR_READY}); end
        checks++; if (OUT_RAM_WORD_MASK !== 4'b0000) begin errors++; $display("FAIL merge_mask_clr got %b exp 0000", OUT_RAM_WORD_MASK); end
        checks++; if (hs_cnt - hs0 !== 1) begin errors++; $display("FAIL merge_hs got %0d exp 1", hs_cnt - hs0); end
    endtask

    task automatic test_overwrite();
        IN_WR_VALID = 1'b1; IN_WR_LINE_ADDR = 8'h05; IN_WR_ADDR_OFFSET = 4'h4; IN_WR_DATA = 32'h11;
        step();
        IN_WR_DATA = 32'h22;
        #1;
        checks++; if (OUT_WR_READY !== 1'b1) begin errors++; $display("FAIL ovw_ready got %b exp 1", OUT_WR_READY); end
        step();
        IN_WR_VALID = 1'b0; IN_FLUSH = 1'b1;
        #1;
        checks++; if (OUT_WR_READY !== 1'b0) begin errors++; $display("FAIL ovw_flush_ready got %b exp 0", OUT_WR_READY); end
        step();
        IN_FLUSH = 1'b0;
        #1;
        checks++; if (OUT_RAM_WR_VALID !== 1'b1) begin errors++; $display("FAIL ovw_ramvalid got %b exp 1", OUT_RAM_WR_VALID); end
        checks++; if (OUT_RAM_WORD_MASK !== 4'b0010) begin errors++; $display("FAIL ovw_mask got %b exp 0010", OUT_RAM_WORD_MASK); end
        checks++; if (OUT_RAM_DATA[63:32] !== 32'h22) begin errors++; $display("FAIL ovw_word1 got %h exp 00000022", OUT_RAM_DATA[63:32]); end
        step();
    endtask

    task automatic test_conflict();
        IN_WR_VALID = 1'b1; IN_WR_LINE_ADDR = 8'h05; IN_WR_ADDR_OFFSET = 4'h0; IN_WR_DATA = 32'h33;
        step();
        IN_WR_LINE_ADDR = 8'h06; IN_WR_ADDR_OFFSET = 4'h8; IN_WR_DATA = 32'h44;
        #1;
        checks++; if (OUT_WR_READY !== 1'b0) begin errors++; $display("FAIL conf_ready got %b exp 0", OUT_WR_READY); end
        step();
        checks++; if (OUT_RAM_WR_VALID !== 1'b1) begin errors++; $display("FAIL conf_ramvalid got %b exp 1", OUT_RAM_WR_VALID); end
        checks++; if (OUT_RAM_LINE_ADDR !== 8'h05) begin errors++; $display("FAIL conf_addr got %h exp 05", OUT_RAM_LINE_ADDR); end
        checks++; if (OUT_RAM_WORD_MASK !== 4'b0001) begin errors++; $display("FAIL conf_mask got %b exp 0001", OUT_RAM_WORD_MASK); end
        checks++; if (OUT_WR_READY !== 1'b0) begin errors++; $display("FAIL conf_drain_ready got %b exp 0", OUT_WR_READY); end
        step();
        checks++; if (OUT_WR_READY !== 1'b1) begin errors++; $display("FAIL conf_idle_ready got %b exp 1", OUT_WR_READY); end
        step();
        IN_WR_VALID = 1'b0; IN_FLUSH = 1'b1;
        step();
        IN_FLUSH = 1'b0;
        #1;
        checks++; if (OUT_RAM_LINE_ADDR !== 8'h06) begin errors++; $display("FAIL conf_addr2 got %h exp 06", OUT_RAM_LINE_ADDR); end
        checks++; if (OUT_RAM_WORD_MASK !== 4'b0100) begin errors++; $display("FAIL conf_mask2 got %b exp 0100", OUT_RAM_WORD_MASK); end
        checks++; if (OUT_RAM_DATA[95:64] !== 32'h44) begin errors++; $display("FAIL conf_word2 got %h exp 00000044", OUT_RAM_DATA[95:64]); end
        step();
    endtask

    task automatic test_backpressure();
        int hs0;
        IN_RAM_WR_READY = 1'b0;
        IN_WR_VALID = 1'b1; IN_WR_LINE_ADDR = 8'h20; IN_WR_ADDR_OFFSET = 4'hC; IN_WR_DATA = 32'h55;
        step();
        IN_WR_VALID = 1'b0; IN_FLUSH = 1'b1;
        step();
        IN_FLUSH = 1'b0;
        hs0 = hs_cnt;
        for (int i = 0; i < 5; i++) begin
            IN_WR_VALID = 1'b1;
            #1;
            checks++; if (OUT_RAM_WR_VALID !== 1'b1) begin errors++; $display("FAIL bp_ramvalid%0d got %b exp 1", i, OUT_RAM_WR_VALID); end
            checks++; if (OUT_WR_READY !== 1'b0) begin errors++; $display("FAIL bp_ready%0d got %b exp 0", i, OUT_WR_READY); end
            checks++; if ({OUT_RAM_LINE_ADDR, OUT_RAM_WORD_MASK, OUT_RAM_DATA[127:96]} !== {8'h20, 4'b1000, 32'h55}) begin errors++; $display("FAIL bp_stable%0d got %h/%b/%h exp 20/1000/00000055", i, OUT_RAM_LINE_ADDR, OUT_RAM_WORD_MASK, OUT_RAM_DATA[127:96]); end
            step();
        end
        IN_WR_VALID = 1'b0;
        checks++; if (hs_cnt - hs0 !== 0) begin errors++; $display("FAIL bp_no_hs got %0d exp 0", hs_cnt - hs0); end
        IN_RAM_WR_READY = 1'b1;
        step();
        checks++; if ({OUT_BUSY, hs_cnt - hs0} !== {1'b0, 32'd1}) begin errors++; $display("FAIL bp_release busy %b hs %0d exp 0 1", OUT_BUSY, hs_cnt - hs0); end
    endtask

    task automatic test_reset_drain();
        int hs0;
        IN_RAM_WR_READY = 1'b0;
        IN_WR_VALID = 1'b1; IN_WR_LINE_ADDR = 8'h30; IN_WR_ADDR_OFFSET = 4'h0; IN_WR_DATA = 32'h77;
        step();
        IN_WR_VALID = 1'b0; IN_FLUSH = 1'b1;
        step();
        IN_FLUSH = 1'b0;
        hs0 = hs_cnt;
        checks++; if (OUT_RAM_WR_VALID !== 1'b1) begin errors++; $display("FAIL rstd_pre got %b exp 1", OUT_RAM_WR_VALID); end
        IN_RESET = 1'b1;
        #1;
        checks++; if ({OUT_RAM_WR_VALID, OUT_BUSY, OUT_WR_READY} !== 3'b001) begin errors++; $display("FAIL rstd_flags valid/busy/ready got %b exp 001", {OUT_RAM_WR_VALID, OUT_BUSY, OUT_WR_READY}); end
        checks++; if (OUT_RAM_WORD_MASK !== 4'b0000) begin errors++; $display("FAIL rstd_mask got %b exp 0000", OUT_RAM_WORD_MASK); end
        IN_RAM_WR_READY = 1'b1;
        step();
        @(negedge IN_CLK);
        IN_RESET = 1'b0;
        step();
        checks++; if (hs_cnt - hs0 !== 0) begin errors++; $display("FAIL rstd_no_hs got %0d exp 0", hs_cnt - hs0); end
    endtask

    task automatic test_timeout();
        IN_WR_VALID = 1'b1; IN_WR_LINE_ADDR = 8'h40; IN_WR_ADDR_OFFSET = 4'h4; IN_WR_DATA = 32'h66;
        step();
        IN_WR_VALID = 1'b0;
`ifdef WMB_TIMEOUT_EN
        for (int i = 0; i < 15; i++) step();
        checks++; if ({OUT_BUSY, OUT_RAM_WR_VALID} !== 2'b10) begin errors++; $display("FAIL tmo_early busy/valid got %b exp 10", {OUT_BUSY, OUT_RAM_WR_VALID}); end
        step();
        checks++; if (OUT_RAM_WR_VALID !== 1'b1) begin errors++; $display("FAIL tmo_drain got %b exp 1", OUT_RAM_WR_VALID); end
        step();
`else
        for (int i = 0; i < 40; i++) step();
        checks++; if ({OUT_BUSY, OUT_RAM_WR_VALID} !== 2'b10) begin errors++; $display("FAIL tmo_off busy/valid got %b exp 10", {OUT_BUSY, OUT_RAM_WR_VALID}); end
        IN_FLUSH = 1'b1;
        step();
        IN_FLUSH = 1'b0;
        step();
`endif
        checks++; if (OUT_BUSY !== 1'b0) begin errors++; $display("FAIL tmo_idle got %b exp 0", OUT_BUSY); end
    endtask

    initial begin
        IN_RESET = 1'b1;
        IN_WR_VALID = 1'b0;
        IN_WR_DATA = 32'h0;
        IN_WR_LINE_ADDR = 8'h0;
        IN_WR_ADDR_OFFSET = 4'h0;
        IN_FLUSH = 1'b0;
        IN_RAM_WR_READY = 1'b1;
        #3;
        test_reset();
        test_full_merge();
        test_overwrite();
        test_conflict();
        test_backpressure();
        test_reset_drain();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/write_merge_buffer.md
WRITE_MERGE_BUFFER -- requirements
Module: write_merge_buffer

Interface
REQ-001 Parameters SHALL be, one per line:
- CPU_W, c_CPU_DATA_SIZE, CPU word width.
- LINE_W, c_RAM_DATA_SIZE, RAM line width; equals 4*CPU_W.
- OFF_W, c_ADDR_OFFSET_SIZE, offset width; OFF_W/2 equals 2.
- TAG_W, 8, line-address width.
- TIMEOUT, 16, idle-cycle flush limit; used only with WMB_TIMEOUT_EN.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- IN_CLK, in, 1, single clock; all state updates on its rising edge.
- IN_RESET, in, 1, reset; asynchronous, active-high.
- IN_WR_VALID, in, 1, CPU write request.
- OUT_WR_READY, out, 1, buffer accepts the write this cycle.
- IN_WR_DATA, in, CPU_W, CPU write word.
- IN_WR_LINE_ADDR, in, TAG_W, line address of the write.
- IN_WR_ADDR_OFFSET, in, OFF_W, byte offset within the line.
- IN_FLUSH, in, 1, force write-back of the pending line.
- OUT_RAM_WR_VALID, out, 1, line write to RAM pending.
- IN_RAM_WR_READY, in, 1, RAM accepts the line.
- OUT_RAM_DATA, out, LINE_W, merged line.
- OUT_RAM_LINE_ADDR, out, TAG_W, line address of the merged line.
- OUT_RAM_WORD_MASK, out, 4, valid-word mask; bit k covers word k.
- OUT_BUSY, out, 1, buffer is not in IDLE.

Function
REQ-003 Slot SHALL be IN_WR_ADDR_OFFSET[OFF_W-1:OFF_W/2]; lower offset bits are ignored.
REQ-004 Word k SHALL occupy OUT_RAM_DATA[(k+1)*CPU_W-1 : k*CPU_W]; this is the inverse of the read-side word select.
REQ-005 States SHALL be IDLE, FILL and DRAIN, register-encoded.
REQ-006 A write SHALL be accepted when IN_WR_VALID and OUT_WR_READY are both high at a rising edge.
REQ-007 OUT_WR_READY SHALL be high when the state is IDLE, or when the state is FILL, IN_WR_LINE_ADDR equals the latched address and IN_FLUSH is low; it is low in DRAIN.
REQ-008 An accept in IDLE SHALL latch the line address, write the slot, set its mask bit and move to FILL.
REQ-009 An accept in FILL SHALL write the slot and set its mask bit; a repeated slot is overwritten (last write wins).
REQ-010 FILL SHALL move to DRAIN on the cycle after the accept that completes mask 4'b1111.
REQ-011 FILL SHALL move to DRAIN when IN_WR_VALID is high with a non-matching address; the write is not accepted and the initiator holds it until after the drain.
REQ-012 FILL SHALL move to DRAIN when IN_FLUSH is high; IN_FLUSH in IDLE or DRAIN has no effect.
REQ-013 OUT_RAM_WR_VALID SHALL be high exactly in DRAIN, and data, address and mask stay stable while it is high.
REQ-014 On DRAIN with IN_RAM_WR_READY high, the mask SHALL clear and the state SHALL return to IDLE at the next edge.
REQ-015 The minimum latency SHALL be one cycle from the causing event to OUT_RAM_WR_VALID, and one cycle from the RAM handshake to OUT_WR_READY.
REQ-016 Unwritten words of OUT_RAM_DATA SHALL hold their previous value, are don't-care, and are excluded by the mask.
REQ-017 OUT_BUSY SHALL be high exactly when the state is not IDLE.

Reset
REQ-018 Assertion of IN_RESET SHALL immediately set state IDLE, mask 0, data 0, line address 0, timeout counter 0, OUT_RAM_WR_VALID 0 and OUT_BUSY 0; OUT_WR_READY is then 1.
REQ-019 Reset during FILL or DRAIN SHALL discard the pending line without any RAM write.

Configuration
REQ-020 With WMB_TIMEOUT_EN defined, FILL SHALL move to DRAIN after TIMEOUT consecutive cycles with no accept.
- The counter clears on every accept and on every entry to FILL.
REQ-021 Without WMB_TIMEOUT_EN, no counter SHALL exist and FILL exits only per REQ-010 to REQ-012.

Verification
REQ-022 The bench SHALL cover the following directed scenarios, with CPU_W=32 and IN_RAM_WR_READY held high unless stated:
- Full merge: addr 0x12, offsets 0x0,0x4,0x8,0xC, data 0xA0..0xA3 -> one RAM write, mask 1111, data 0x000000A3_000000A2_000000A1_000000A0.
- Overwrite: addr 0x05, offset 0x4 with data 0x11, then 0x22, then IN_FLUSH -> mask 0010, word1 = 0x22.
- Conflict: FILL on 0x05, write to 0x06 -> OUT_WR_READY 0, line 0x05 drains, then the 0x06 write is accepted from IDLE.
- Backpressure: IN_RAM_WR_READY low for 5 cycles in DRAIN -> OUT_RAM_WR_VALID high with outputs stable for 5 cycles, OUT_WR_READY 0 throughout.
- Reset mid-DRAIN: assert IN_RESET -> OUT_RAM_WR_VALID 0 immediately, no handshake occurs, mask 0.
- Timeout (macro on): a single write, then idle -> DRAIN entered after 16 idle cycles; with the macro off, the buffer stays in FILL indefinitely.
